// File: rtl/verify_stream_sequencer.sv
// Verify-mode sequencer: streams rho, c, z, t1, h, msg_len and msg
// from the host into the signature core and reports its verdict.
module verify_stream_sequencer #(
  parameter int HIGH_PERF  = 1,
  parameter int W          = 64,
  parameter int SEED_WORDS = 4,
  parameter int Z_WORDS    = 80,
  parameter int T1_WORDS   = 80,
  parameter int H_WORDS    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_msg_len,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         core_start,
  output logic [1:0]   core_mode,
  output logic         core_valid_i,
  input  logic         core_ready_i,
  output logic [W-1:0] core_data_i,
  input  logic         core_valid_o,
  output logic         core_ready_o,
  input  logic [W-1:0] core_data_o,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_accept,
  output logic [31:0]  res_cycles,
  output logic         busy
);

  localparam int CW = W + 4;
  localparam logic [1:0] VERIFY_MODE = 2'd2;

  typedef enum logic [3:0] {
    IDLE, START, RHO, C, Z, T1, H,
    MLEN, MSG, WAIT_RES, REPORT
  } state_t;

  state_t state_q, state_d, seg_next;

  logic [W-1:0]  len_q;
  logic [CW-1:0] mwords_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] seg_len;
  logic [31:0]   cyc_q;
  logic [31:0]   cyc_inc;
  logic [31:0]   res_cyc_q;
  logic          acc_q;
  logic          live_q;
  logic          payload;
  logic          xfer;
  logic          seg_last;
  logic          capture;

  assign payload = (state_q == RHO) || (state_q == C)
                || (state_q == Z)   || (state_q == T1)
                || (state_q == H)   || (state_q == MSG);

  assign xfer     = payload && src_valid && core_ready_i;
  assign seg_last = xfer && (cnt_q == seg_len - CW'(1));
  assign capture  = (state_q == WAIT_RES) && core_valid_o;
  assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + 32'd1;

  always_comb begin
    seg_len = '0;
    case (state_q)
      RHO, C:  seg_len = CW'(SEED_WORDS);
      Z:       seg_len = CW'(Z_WORDS);
      T1:      seg_len = CW'(T1_WORDS);
      H:       seg_len = CW'(H_WORDS);
      MSG:     seg_len = mwords_q;
      default: seg_len = '0;
    endcase
  end

  // An empty message skips MSG straight to the following segment
  always_comb begin
    seg_next = IDLE;
    if (HIGH_PERF != 0) begin
      case (state_q)
        RHO:     seg_next = C;
        C:       seg_next = Z;
        Z:       seg_next = T1;
        T1:      seg_next = MLEN;
        MLEN:    seg_next = (mwords_q == '0) ? H : MSG;
        MSG:     seg_next = H;
        H:       seg_next = WAIT_RES;
        default: seg_next = IDLE;
      endcase
    end else begin
      case (state_q)
        RHO:     seg_next = T1;
        T1:      seg_next = C;
        C:       seg_next = Z;
        Z:       seg_next = H;
        H:       seg_next = MLEN;
        MLEN:    seg_next = (mwords_q == '0) ? WAIT_RES : MSG;
        MSG:     seg_next = WAIT_RES;
        default: seg_next = IDLE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid && live_q) state_d = START;
      START:    state_d = RHO;
      MLEN:     if (core_ready_i) state_d = seg_next;
      WAIT_RES: if (core_valid_o) state_d = REPORT;
      REPORT:   if (res_ready) state_d = IDLE;
      default:  if (seg_last) state_d = seg_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      len_q     <= '0;
      mwords_q  <= '0;
      cnt_q     <= '0;
      cyc_q     <= '0;
      res_cyc_q <= '0;
      acc_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (state_q == IDLE && cmd_valid && live_q)
        len_q <= cmd_msg_len;
      if (state_q == START) begin
        mwords_q <= ((CW'(len_q) << 3) + CW'(W - 1)) / CW'(W);
        cnt_q    <= '0;
        cyc_q    <= '0;
      end else begin
        if (seg_last)
          cnt_q <= '0;
        else if (xfer)
          cnt_q <= cnt_q + CW'(1);
        if (busy && state_q != REPORT)
          cyc_q <= cyc_inc;
      end
      if (capture) begin
        res_cyc_q <= cyc_inc;
        acc_q     <= (core_data_o != W'(HIGH_PERF));
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign cmd_ready  = (state_q == IDLE) && live_q;
  assign core_start = (state_q == START);
  assign core_mode  = VERIFY_MODE;
  assign res_accept = acc_q;
  assign res_cycles = res_cyc_q;

  always_comb begin
    core_valid_i = 1'b0;
    core_data_i  = '0;
    src_ready    = 1'b0;
    core_ready_o = 1'b0;
    res_valid    = 1'b0;
    unique case (1'b1)
      payload: begin
        core_valid_i = src_valid;
        core_data_i  = src_data;
        src_ready    = core_ready_i;
      end
      (state_q == MLEN): begin
        core_valid_i = 1'b1;
        core_data_i  = len_q;
      end
      (state_q == WAIT_RES): core_ready_o = 1'b1;
      (state_q == REPORT):   res_valid    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/verify_stream_sequencer.md
VERIFY_STREAM_SEQUENCER -- requirements
Module: verify_stream_sequencer

Interface
REQ-001 Parameters SHALL be:
  - HIGH_PERF, default 1: selects segment order and result encoding.
  - W, default 64: data word width.
  - SEED_WORDS, default 4: words in each of rho and c.
  - Z_WORDS, default 80: words in z.
  - T1_WORDS, default 80: words in t1.
  - H_WORDS, default 2: words in h.
REQ-002 Ports SHALL be:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous active-low reset.
  - cmd_valid  in  1  start-command valid.
  - cmd_ready  out  1  start-command ready.
  - cmd_msg_len  in  W  message length in bytes.
  - src_valid  in  1  host payload word valid.
  - src_ready  out  1  host payload word ready.
  - src_data  in  W  host payload word.
  - core_start  out  1  one-cycle start pulse to the core.
  - core_mode  out  2  constant VERIFY_MODE.
  - core_valid_i  out  1  word valid to the core.
  - core_ready_i  in  1  core accepts a word.
  - core_data_i  out  W  word to the core.
  - core_valid_o  in  1  core result valid.
  - core_ready_o  out  1  result ready to the core.
  - core_data_o  in  W  core result.
  - res_valid  out  1  verdict valid.
  - res_ready  in  1  verdict consumed.
  - res_accept  out  1  1 = signature accepted.
  - res_cycles  out  32  cycles from start to result.
  - busy  out  1  high in every state except IDLE.
REQ-003 One clock and an asynchronous, active-low reset; ports are named clk and rst_n.

Function
REQ-004 States SHALL be: IDLE, START, RHO, C, Z, T1, H, MLEN, MSG, WAIT_RES, REPORT.
REQ-005 IDLE: cmd_ready=1. On cmd_valid, latch cmd_msg_len, then go to START.
REQ-006 START: assert core_start for exactly one cycle, clear the cycle counter, then go to RHO.
REQ-007 Segment order when HIGH_PERF=1: RHO, C, Z, T1, MLEN, MSG, H, WAIT_RES.
REQ-008 Segment order when HIGH_PERF=0: RHO, T1, C, Z, H, MLEN, MSG, WAIT_RES.
REQ-009 Payload states (RHO, C, Z, T1, H, MSG) SHALL pass words straight through:
  - core_valid_i = src_valid.
  - src_ready = core_ready_i.
  - core_data_i = src_data.
  - No added latency and no buffering.
REQ-010 One word transfers on a cycle with src_valid && core_ready_i. The word counter increments only on a transfer.
REQ-011 Each segment ends on the transfer of its last word, at counts SEED_WORDS, Z_WORDS, T1_WORDS, H_WORDS or msg_words. The counter returns to 0 and the next segment starts on the following cycle.
REQ-012 msg_words = ceil(msg_len*8/W), computed in at least 35-bit unsigned arithmetic.
REQ-013 If msg_len==0, MSG SHALL be skipped entirely and no host word consumed.
REQ-014 MLEN: drive core_valid_i=1, core_data_i=zero-extended msg_len, src_ready=0. Advance on core_ready_i.
REQ-015 src_ready SHALL be 0 in IDLE, START, MLEN, WAIT_RES and REPORT.
REQ-016 WAIT_RES: core_ready_o=1. On core_valid_o, capture the result and go to REPORT:
  - res_accept = (core_data_o != HIGH_PERF).
  - High-perf core: 0 = accept.
  - Low-res core: 1 = accept.
REQ-017 REPORT: res_valid=1, with res_accept and res_cycles held stable. On res_ready, return to IDLE.
REQ-018 Cycle counter increments every cycle from the cycle after START through the WAIT_RES capture cycle inclusive. It saturates at 0xFFFFFFFF and does not wrap.
REQ-019 A cmd_valid outside IDLE SHALL be ignored (cmd_ready=0).
REQ-020 core_valid_i SHALL never be high in IDLE, START, WAIT_RES or REPORT.

Reset
REQ-021 On rst_n=0, asynchronously and without waiting for a clock edge:
  - State = IDLE.
  - All counters = 0.
  - Outputs = 0: core_start, core_valid_i, core_ready_o, src_ready, res_valid, res_accept, res_cycles, busy.
  - cmd_ready = 0 while rst_n is low, 1 after the first edge with rst_n high.
REQ-022 Reset asserted mid-segment SHALL drop any word in flight without a handshake. The next command restarts from RHO.

Verification
REQ-023 HIGH_PERF=1, W=64, msg_len=33, host always valid, core always ready:
  - Exactly 4+4+80+80+1+5+2 = 176 core transfers, in order.
  - Word 169 = 33.
  - Core returns 0 -> res_accept=1.
REQ-024 HIGH_PERF=0, msg_len=0:
  - Order rho, t1, c, z, h, then the MLEN word.
  - No MSG words consumed; core_data_o=0 -> res_accept=0.
REQ-025 Random stalls on both src_valid and core_ready_i (50%):
  - Transferred word sequence identical to the no-stall run.
  - No duplicated or dropped words.
REQ-026 Core holds core_valid_o low for 2^32+10 cycles -> res_cycles=0xFFFFFFFF.
REQ-027 rst_n pulsed low during Z word 40:
  - Outputs clear immediately.
  - A new command then streams correctly from RHO word 0.
REQ-028 res_ready held low for 20 cycles in REPORT:
  - res_valid and outputs stable.
  - A cmd_valid during REPORT is ignored.
